// File: rtl/fetch_queue_pkg.sv
// Purpose : shared types and helpers for the fetch stage and its instruction queue.
// Latency : n/a (types only).
// Backpressure: n/a.
package fetch_queue_pkg;

    localparam int ISA_ADDR_W = 32;
    localparam int ISA_WORD_W = 32;

    typedef logic [ISA_WORD_W-1:0] word_t;

    // Queue entry at the default ISA widths. fetch_queue rebuilds an equivalent
    // struct from its own parameters so non-default widths also work.
    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  pred_taken;
    } fetch_entry_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Purpose : bundles the imem, predictor, redirect and dispatch signals of the fetch stage.
// Latency : n/a (wiring only).
// Backpressure: deq_ready from dispatch; full/stall gate imem_ren on the fetch side.
// master = fetch_queue side, slave = memory / predictor / backend / dispatch side.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = cnt_width(DEPTH);

    // imem
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              imem_ren;
    logic [ADDR_W-1:0] imem_addr;
    // predictor
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_prediction;
    logic              pred_taken;
    // backend control
    logic              misprediction;
    logic [ADDR_W-1:0] correct_pc;
    logic              stall;
    // dispatch
    logic              deq_valid;
    logic              deq_ready;
    logic [WORD_W-1:0] deq_instr;
    logic [ADDR_W-1:0] deq_pc;
    logic              deq_pred_taken;
    logic [CNT_W-1:0]  count;
    logic              full;

    modport master (
        input  ihit, imemload, pc_prediction, pred_taken,
               misprediction, correct_pc, stall, deq_ready,
        output imem_ren, imem_addr, fetch_pc,
               deq_valid, deq_instr, deq_pc, deq_pred_taken, count, full
    );

    modport slave (
        output ihit, imemload, pc_prediction, pred_taken,
               misprediction, correct_pc, stall, deq_ready,
        input  imem_ren, imem_addr, fetch_pc,
               deq_valid, deq_instr, deq_pc, deq_pred_taken, count, full
    );

endinterface

// File: rtl/fetch_fifo.sv
// Purpose : generic DEPTH x W synchronous FIFO with single-cycle flush.
// Latency : write visible at rdata one cycle after push (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
// Ports: push/wdata write side, pop/rdata read side (rdata = head), flush clears
// pointers and count, count/full/empty are registered occupancy.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 65,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             wr;
    logic             rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wr    = push && !full && !flush;
    assign rd    = pop && !empty && !flush;
    assign rdata = mem[head];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr) tail <= tail + PTR_W'(1);
            if (rd) head <= head + PTR_W'(1);
            case ({wr, rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; reset and flush only invalidate via the pointers.
    always_ff @(posedge CLK) begin
        if (wr) mem[tail] <= wdata;
    end

endmodule

// File: rtl/fetch_queue.sv
// Purpose : fetch stage: PC register, blocking imem requests, DEPTH-entry instruction queue.
// Latency : ihit -> deq_valid is 1 cycle; misprediction flushes and redirects in 1 cycle.
// Backpressure: deq_ready stalls the queue head; a registered full (or stall) drops imem_ren.
// Ports: CLK, nRST (async active-low), bus = fetch_queue_if.master carrying imem
// request/response, predictor lookup, redirect/stall and the dispatch handshake.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               ADDR_W  = 32,
    parameter int               WORD_W  = 32,
    parameter int               DEPTH   = 4,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_queue_if.master bus
);

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic              pred_taken;
    } entry_t;

    localparam int CNT_W = cnt_width(DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    logic              push;
    logic              pop;
    entry_t            wr_entry;
    entry_t            rd_entry;

    // Request uses only registered full, so deq_ready never reaches imem_ren
    // combinationally; a full queue waits one cycle after a pop before refetching.
    assign bus.imem_ren  = !q_full && !bus.stall && !bus.misprediction;
    assign bus.imem_addr = pc_q;
    assign bus.fetch_pc  = pc_q;

    assign push = bus.ihit && bus.imem_ren;
    assign pop  = !q_empty && bus.deq_ready && !bus.misprediction;

    assign wr_entry.instr      = bus.imemload;
    assign wr_entry.pc         = pc_q;
    assign wr_entry.pred_taken = bus.pred_taken;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q <= PC_INIT;
        end else if (bus.misprediction) begin
            pc_q <= bus.correct_pc;
        end else if (push) begin
            pc_q <= bus.pc_prediction;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push),
        .pop   (pop),
        .flush (bus.misprediction),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign bus.deq_valid      = !q_empty;
    assign bus.deq_instr      = rd_entry.instr;
    assign bus.deq_pc         = rd_entry.pc;
    assign bus.deq_pred_taken = rd_entry.pred_taken;
    assign bus.count          = q_count;
    assign bus.full           = q_full;

endmodule

// File: tb/tb_fetch_queue.sv
// Purpose : directed self-checking bench for fetch_queue (DEPTH=4, 32-bit).
// Latency : checks taken 1 time unit after each rising edge.
// Backpressure: dispatch ready and stall driven per scenario.
module tb_fetch_queue;

    logic        CLK;
    logic        nRST;
    int          checks;
    int          errors;
    logic [31:0] e;

    fetch_queue_if #(.ADDR_W(32), .WORD_W(32), .DEPTH(4)) bus();

    fetch_queue #(
        .ADDR_W  (32),
        .WORD_W  (32),
        .DEPTH   (4),
        .PC_INIT (32'h0)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Environment models: sequential predictor, memory returns ~address,
    // taken bit is a fixed function of the PC.
    assign bus.pc_prediction = bus.fetch_pc + 32'd4;
    assign bus.imemload      = ~bus.imem_addr;
    assign bus.pred_taken    = bus.fetch_pc[2] ^ bus.fetch_pc[4];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic init_inputs();
        bus.ihit          = 1'b0;
        bus.misprediction = 1'b0;
        bus.correct_pc    = 32'h0;
        bus.stall         = 1'b0;
        bus.deq_ready     = 1'b0;
    endtask

    task automatic do_reset();
        init_inputs();
        nRST = 1'b0;
        #3;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        init_inputs();
        nRST = 1'b0;
        #2;
        checks++; if (bus.fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.fetch_pc, 32'h0); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got %b exp 0", bus.deq_valid); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
        checks++; if (bus.imem_ren !== 1'b1) begin errors++; $display("FAIL reset_ren got %b exp 1", bus.imem_ren); end
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_stream();
        do_reset();
        bus.ihit = 1'b1;
        bus.deq_ready = 1'b1;
        #1;
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL stream_addr0 got %h exp 0", bus.imem_addr); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            e = 32'(4 * (i - 1));
            checks++; if (bus.fetch_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, bus.fetch_pc, 32'(4 * i)); end
            checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== e) begin errors++; $display("FAIL stream_deq[%0d] got v=%b pc=%h exp v=1 pc=%h", i, bus.deq_valid, bus.deq_pc, e); end
            checks++; if (bus.deq_instr !== ~e) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, bus.deq_instr, ~e); end
            checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", i, bus.count); end
        end
        init_inputs();
    endtask

    task automatic test_fill();
        do_reset();
        bus.ihit = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (bus.count !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, i); end
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", bus.full); end
        checks++; if (bus.imem_ren !== 1'b0) begin errors++; $display("FAIL fill_ren got %b exp 0", bus.imem_ren); end
        checks++; if (bus.fetch_pc !== 32'h10) begin errors++; $display("FAIL fill_pc got %h exp 10", bus.fetch_pc); end
        tick();
        checks++; if (bus.count !== 3'd4 || bus.fetch_pc !== 32'h10) begin errors++; $display("FAIL fill_hold got cnt=%0d pc=%h exp cnt=4 pc=10", bus.count, bus.fetch_pc); end
        bus.deq_ready = 1'b1;
        #1;
        checks++; if (bus.imem_ren !== 1'b0) begin errors++; $display("FAIL fill_ren_on_pop got %b exp 0", bus.imem_ren); end
        tick();
        bus.deq_ready = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd3 || bus.full !== 1'b0) begin errors++; $display("FAIL fill_pop got cnt=%0d full=%b exp cnt=3 full=0", bus.count, bus.full); end
        checks++; if (bus.imem_ren !== 1'b1) begin errors++; $display("FAIL fill_ren_after got %b exp 1", bus.imem_ren); end
        checks++; if (bus.deq_pc !== 32'h4) begin errors++; $display("FAIL fill_head got %h exp 4", bus.deq_pc); end
        tick();
        checks++; if (bus.count !== 3'd4 || bus.fetch_pc !== 32'h14) begin errors++; $display("FAIL fill_refill got cnt=%0d pc=%h exp cnt=4 pc=14", bus.count, bus.fetch_pc); end
        init_inputs();
    endtask

    task automatic test_mispredict();
        do_reset();
        bus.ihit = 1'b1;
        repeat (3) tick();
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL misp_pre_count got %0d exp 3", bus.count); end
        bus.misprediction = 1'b1;
        bus.correct_pc    = 32'h100;
        bus.deq_ready     = 1'b1;
        #1;
        checks++; if (bus.imem_ren !== 1'b0) begin errors++; $display("FAIL misp_ren got %b exp 0", bus.imem_ren); end
        tick();
        bus.misprediction = 1'b0;
        bus.ihit = 1'b0;
        bus.deq_ready = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0) begin errors++; $display("FAIL misp_flush got cnt=%0d v=%b exp cnt=0 v=0", bus.count, bus.deq_valid); end
        checks++; if (bus.fetch_pc !== 32'h100 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL misp_pc got pc=%h addr=%h exp 100", bus.fetch_pc, bus.imem_addr); end
        checks++; if (bus.imem_ren !== 1'b1) begin errors++; $display("FAIL misp_ren_after got %b exp 1", bus.imem_ren); end
        bus.ihit = 1'b1;
        tick();
        bus.ihit = 1'b0;
        #1;
        checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== 32'h100) begin errors++; $display("FAIL misp_head got v=%b pc=%h exp v=1 pc=100", bus.deq_valid, bus.deq_pc); end
        checks++; if (bus.count !== 3'd1 || bus.fetch_pc !== 32'h104) begin errors++; $display("FAIL misp_next got cnt=%0d pc=%h exp cnt=1 pc=104", bus.count, bus.fetch_pc); end
        init_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        bus.ihit = 1'b1;
        repeat (3) tick();
        bus.stall = 1'b1;
        bus.deq_ready = 1'b1;
        #1;
        checks++; if (bus.imem_ren !== 1'b0) begin errors++; $display("FAIL stall_ren got %b exp 0", bus.imem_ren); end
        for (int i = 1; i <= 3; i++) begin
            e = 32'(4 * (i - 1));
            checks++; if (bus.deq_pc !== e) begin errors++; $display("FAIL stall_head[%0d] got %h exp %h", i, bus.deq_pc, e); end
            tick();
            checks++; if (bus.count !== 3'(3 - i) || bus.fetch_pc !== 32'hC) begin errors++; $display("FAIL stall_step[%0d] got cnt=%0d pc=%h exp cnt=%0d pc=c", i, bus.count, bus.fetch_pc, 3 - i); end
        end
        checks++; if (bus.deq_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b exp 0", bus.deq_valid); end
        bus.stall = 1'b0;
        bus.deq_ready = 1'b0;
        #1;
        checks++; if (bus.imem_ren !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", bus.imem_ren); end
        init_inputs();
    endtask

    task automatic test_wrap();
        int          pops;
        logic [31:0] exp_pc;
        logic        exp_pt;
        do_reset();
        pops   = 0;
        exp_pc = 32'h0;
        for (int cyc = 0; cyc < 100 && pops < 10; cyc++) begin
            bus.ihit      = (bus.fetch_pc < 32'd40);
            bus.deq_ready = (cyc % 2 == 0);
            #1;
            if (bus.deq_valid && bus.deq_ready) begin
                exp_pt = exp_pc[2] ^ exp_pc[4];
                checks++; if (bus.deq_pc !== exp_pc) begin errors++; $display("FAIL wrap_pc[%0d] got %h exp %h", pops, bus.deq_pc, exp_pc); end
                checks++; if (bus.deq_pred_taken !== exp_pt) begin errors++; $display("FAIL wrap_pt[%0d] got %b exp %b", pops, bus.deq_pred_taken, exp_pt); end
                checks++; if (bus.deq_instr !== ~exp_pc) begin errors++; $display("FAIL wrap_instr[%0d] got %h exp %h", pops, bus.deq_instr, ~exp_pc); end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            tick();
        end
        checks++; if (pops != 10) begin errors++; $display("FAIL wrap_budget got %0d pops exp 10", pops); end
        init_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.ihit = 1'b1;
        repeat (2) tick();
        bus.ihit = 1'b0;
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL arst_pre_count got %0d exp 2", bus.count); end
        #3;
        nRST = 1'b0;
        #1;
        checks++; if (bus.fetch_pc !== 32'h0) begin errors++; $display("FAIL arst_pc got %h exp 0", bus.fetch_pc); end
        checks++; if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL arst_state got cnt=%0d v=%b full=%b exp 0", bus.count, bus.deq_valid, bus.full); end
        #1;
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_fill();
        test_mispredict();
        test_stall();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised next-generation fetch stage. Holds the fetch PC and issues blocking instruction-memory reads.
- Each returned instruction is pushed, with its PC and prediction bit, into a DEPTH-entry instruction queue.
- Dispatch drains the queue with a valid/ready handshake, so fetch runs ahead of a stalled dispatch.
- Misprediction redirects the PC and flushes the whole queue in one cycle.

Parameters:
ADDR_W, 32, PC / address width
WORD_W, 32, instruction width
DEPTH, 4, queue entries; power of two, >= 2
PC_INIT, 0, PC value loaded at reset

Ports:
CLK  input  1  clock
nRST  input  1  reset; one clock, asynchronous, active-low
ihit  input  1  imem returned imemload for imem_addr this cycle
imemload  input  WORD_W  instruction data, valid when ihit
imem_ren  output  1  read request
imem_addr  output  ADDR_W  read address (= fetch_pc)
fetch_pc  output  ADDR_W  current fetch PC, drives external predictor lookup
pc_prediction  input  ADDR_W  predicted next PC for fetch_pc (combinational from predictor)
pred_taken  input  1  predictor says taken for fetch_pc
misprediction  input  1  redirect request from backend
correct_pc  input  ADDR_W  redirect target
stall  input  1  freeze new fetches; dequeue unaffected
deq_valid  output  1  queue head valid
deq_ready  input  1  dispatch accepts head
deq_instr  output  WORD_W  head instruction
deq_pc  output  ADDR_W  head PC
deq_pred_taken  output  1  head prediction bit
count  output  $clog2(DEPTH+1)  occupied entries
full  output  1  count == DEPTH

Behaviour:
Reset:
- fetch_pc = PC_INIT, count = 0, deq_valid = 0, full = 0.
- Pointers = 0.
- imem_ren = 1 when stall is low.

Request and PC:
- imem_ren = !full && !stall && !misprediction; imem_addr = fetch_pc.
- fetch_pc holds until accepted.

Push:
- A push occurs when ihit && imem_ren.
- Enqueue {fetch_pc, imemload, pred_taken}; fetch_pc <= pc_prediction.

Pop:
- A pop occurs when deq_valid && deq_ready && !misprediction.
- Head pointer advances.

Queue rules:
- push && pop in the same cycle: count unchanged, both pointers advance.
- Push uses the registered full only. A full queue does not accept a push even with a simultaneous pop, so there is no combinational path from deq_ready to imem_ren.
- No bypass: a push into an empty queue makes deq_valid = 1 on the next cycle. Latency ihit -> deq_valid is 1 cycle.
- Pointers wrap modulo DEPTH. count saturates by construction; overflow and underflow are impossible.
- deq_* outputs come from the head entry and are don't-care when deq_valid = 0.

Misprediction (highest priority):
- Next cycle: fetch_pc = correct_pc, count = 0, pointers = 0, deq_valid = 0.
- Any ihit and deq_ready in that cycle are ignored; the response is dropped.
- The following cycle requests correct_pc, unless stall is high.

Stall:
- No push; fetch_pc holds; ihit is ignored (imem_ren = 0).
- Pops continue.

Full:
- imem_ren = 0 and fetch_pc holds until a pop frees an entry.

State:
- The queue state machine is implicit in count: EMPTY (0), PARTIAL, FULL (DEPTH).
- Transitions: +1 on push only, -1 on pop only, 0 on both or neither, 0 on misprediction.

Reset mid-operation:
- Asynchronous clear to the reset values above.
- Queue contents are not cleared, only invalidated via the pointers.

Decomposition:
- isa_pkg gains fetch_entry_t {word_t instr; word_t pc; logic pred_taken;} for default widths.
- The module builds its entry from parameters, so isa_pkg is not required when widths differ.
- One sub-module: fetch_fifo, a generic DEPTH x W synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head data, count, full, empty.
- fetch_queue contains the PC register, request logic and handshake glue.

Test Plan:
1. Reset, PC_INIT=0, ihit every cycle, pc_prediction=fetch_pc+4, deq_ready=1 -> fetch_pc 0,4,8,…; deq_pc 0,4,8 starting 1 cycle after each ihit; count stays 1 (one in, one out per cycle).
2. deq_ready=0, ihit every cycle, DEPTH=4 -> count 1,2,3,4; full=1; imem_ren=0; fetch_pc holds 0x10. Then deq_ready=1 for one cycle -> count 3, full=0, imem_ren=1 the next cycle.
3. Queue holding 3 entries; misprediction=1, correct_pc=0x100, ihit=1 in the same cycle -> next cycle count=0, deq_valid=0, fetch_pc=0x100, imem_addr=0x100; the dropped response never appears at deq.
4. stall=1 for 3 cycles with entries queued and deq_ready=1 -> imem_ren=0, fetch_pc constant, count decrements to 0; ihit during the stall causes no push.
5. Wrap: DEPTH=4, enqueue/dequeue 10 instructions with deq_ready toggling 1,0,1,0 -> deq_pc order strictly preserved across pointer wrap; pred_taken bits match per-PC stimulus.
6. nRST asserted asynchronously mid-stream, between clock edges with count=2 -> outputs immediately at reset values (fetch_pc=PC_INIT, deq_valid=0, count=0).
